// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the two-layer convolution engine sequencer.
package conv_pkg;

    localparam int N      = 4;
    localparam int ADDR_W = 7;
    localparam int WDOG_W = 12;

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [N*4-1:0][7:0]   wr_data_t;
    typedef logic [WDOG_W-1:0]     wdog_t;
    typedef logic [3:0]            pass_t;

    typedef enum logic [3:0] {
        IDLE,
        FL_GO,
        FL_RUN,
        SWAP,
        SL_GO,
        SL_RUN,
        NEXT,
        FIN,
        ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FL,
        OWN_SL
    } owner_t;

    // Base of a second-layer pass; wraps modulo the address space.
    function automatic addr_t pass_base(pass_t idx, int stride);
        return addr_t'(int'(idx) * stride);
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if: start/done, layer handshakes and shared write port.
interface conv_layer_sequencer_if;
    import conv_pkg::*;

    logic     start;
    logic     fl_start;
    logic     fl_done;
    logic     fl_wr_en;
    addr_t    fl_wr_addr;
    wr_data_t fl_wr_data;
    logic     sl_start;
    logic     sl_done;
    logic     sl_wr_en;
    addr_t    sl_wr_addr;
    wr_data_t sl_wr_data;
    logic     mem_wr_en;
    addr_t    mem_wr_addr;
    wr_data_t mem_wr_data;
    logic     bank_sel;
    pass_t    pass_idx;
    logic     busy;
    logic     done;
    logic     err;

    modport master (
        input  start, fl_done, fl_wr_en, fl_wr_addr, fl_wr_data,
        input  sl_done, sl_wr_en, sl_wr_addr, sl_wr_data,
        output fl_start, sl_start, mem_wr_en, mem_wr_addr, mem_wr_data,
        output bank_sel, pass_idx, busy, done, err
    );

    modport slave (
        output start, fl_done, fl_wr_en, fl_wr_addr, fl_wr_data,
        output sl_done, sl_wr_en, sl_wr_addr, sl_wr_data,
        input  fl_start, sl_start, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  bank_sel, pass_idx, busy, done, err
    );

endinterface

// File: rtl/seq_wr_mux.sv
// seq_wr_mux: picks the owning layer's write, rebases second-layer
// addresses per pass and registers the shared memory write port.
module seq_wr_mux
    import conv_pkg::*;
#(
    parameter int PASS_STRIDE = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  owner_t   owner,
    input  pass_t    pass_idx,
    input  logic     fl_wr_en,
    input  addr_t    fl_wr_addr,
    input  wr_data_t fl_wr_data,
    input  logic     sl_wr_en,
    input  addr_t    sl_wr_addr,
    input  wr_data_t sl_wr_data,
    output logic     mem_wr_en,
    output addr_t    mem_wr_addr,
    output wr_data_t mem_wr_data,
    output logic     wr_viol
);

    logic     sel_en;
    addr_t    sel_addr;
    wr_data_t sel_data;

    // A write from the layer that does not own the port is dropped.
    always_comb begin
        sel_en   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        wr_viol  = 1'b0;
        unique case (1'b1)
            (owner == OWN_FL): begin
                sel_en   = fl_wr_en;
                sel_addr = fl_wr_addr;
                sel_data = fl_wr_data;
                wr_viol  = sl_wr_en;
            end
            (owner == OWN_SL): begin
                sel_en   = sl_wr_en;
                sel_addr = sl_wr_addr + pass_base(pass_idx, PASS_STRIDE);
                sel_data = sl_wr_data;
                wr_viol  = fl_wr_en;
            end
            default: begin
                wr_viol = fl_wr_en | sl_wr_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= sel_en;
            if (sel_en) begin
                mem_wr_addr <= sel_addr;
                mem_wr_data <= sel_data;
            end
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: runs layer 1 once, then layer 2 once per filter
// group, with a per-layer watchdog and ping-pong bank toggle.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_PASSES  = 2,
    parameter int PASS_STRIDE = 32,
    parameter int TIMEOUT     = 4095
) (
    input logic                    clk,
    input logic                    rst,
    conv_layer_sequencer_if.master bus
);

    seq_state_t state;
    wdog_t      wdog;
    pass_t      pass_idx;
    logic       fl_start;
    logic       sl_start;
    logic       done;
    logic       busy;
    logic       err;
    logic       bank_sel;
    owner_t     owner;
    logic       wr_viol;
    logic       last_pass;
    logic       wdog_hit;

    always_comb begin
        owner = OWN_NONE;
        case (state)
            FL_GO, FL_RUN:        owner = OWN_FL;
            SL_GO, SL_RUN, NEXT:  owner = OWN_SL;
            default:              owner = OWN_NONE;
        endcase
    end

    assign last_pass = (pass_idx == pass_t'(NUM_PASSES - 1));
    assign wdog_hit  = (wdog == wdog_t'(TIMEOUT - 1));

    // A done pulse takes priority over the watchdog expiring.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wdog     <= '0;
            pass_idx <= '0;
            fl_start <= 1'b0;
            sl_start <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            bank_sel <= 1'b0;
        end else begin
            fl_start <= 1'b0;
            sl_start <= 1'b0;
            done     <= 1'b0;
            if (wr_viol) err <= 1'b1;
            unique case (state)
                IDLE, ERR: begin
                    if (bus.start) begin
                        state    <= FL_GO;
                        fl_start <= 1'b1;
                        busy     <= 1'b1;
                        pass_idx <= '0;
                        err      <= wr_viol;
                    end
                end
                FL_GO: begin
                    state <= FL_RUN;
                    wdog  <= '0;
                end
                FL_RUN: begin
                    if (bus.fl_done) begin
                        state    <= SWAP;
                        bank_sel <= ~bank_sel;
                    end else if (wdog_hit) begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                SWAP: begin
                    state    <= SL_GO;
                    sl_start <= 1'b1;
                end
                SL_GO: begin
                    state <= SL_RUN;
                    wdog  <= '0;
                end
                SL_RUN: begin
                    if (bus.sl_done) begin
                        if (last_pass) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= NEXT;
                            pass_idx <= pass_idx + 1'b1;
                        end
                    end else if (wdog_hit) begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                NEXT: begin
                    state    <= SL_GO;
                    sl_start <= 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    pass_idx <= '0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_wr_mux #(
        .PASS_STRIDE (PASS_STRIDE)
    ) u_wr_mux (
        .clk         (clk),
        .rst_n       (rst),
        .owner       (owner),
        .pass_idx    (pass_idx),
        .fl_wr_en    (bus.fl_wr_en),
        .fl_wr_addr  (bus.fl_wr_addr),
        .fl_wr_data  (bus.fl_wr_data),
        .sl_wr_en    (bus.sl_wr_en),
        .sl_wr_addr  (bus.sl_wr_addr),
        .sl_wr_data  (bus.sl_wr_data),
        .mem_wr_en   (bus.mem_wr_en),
        .mem_wr_addr (bus.mem_wr_addr),
        .mem_wr_data (bus.mem_wr_data),
        .wr_viol     (wr_viol)
    );

    assign bus.fl_start = fl_start;
    assign bus.sl_start = sl_start;
    assign bus.bank_sel = bank_sel;
    assign bus.pass_idx = pass_idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: randomized frames checked against a
// transaction-level model of the sequencer.
module tb_conv_layer_sequencer;
    import conv_pkg::*;

    localparam int NUM_PASSES  = 2;
    localparam int PASS_STRIDE = 32;
    localparam int TIMEOUT     = 4095;

    typedef struct packed {
        addr_t    a;
        wr_data_t d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    int  n_chk = 0;
    int  n_pass = 0;
    int  fl_starts = 0;
    int  sl_starts = 0;
    int  dones = 0;
    bit  bank_model = 1'b0;
    wr_t exp_q[$];
    wr_t last_wr = '0;

    conv_layer_sequencer_if bus();

    conv_layer_sequencer #(
        .NUM_PASSES  (NUM_PASSES),
        .PASS_STRIDE (PASS_STRIDE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic wr_data_t rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic addr_t sl_exp_addr(addr_t a, int p);
        return addr_t'((int'(a) + p * PASS_STRIDE) % (1 << ADDR_W));
    endfunction

    // Write port monitor: committed writes in order, otherwise held values.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_wr = '0;
            end else begin
                if (bus.fl_start) fl_starts++;
                if (bus.sl_start) sl_starts++;
                if (bus.done) dones++;
                if (bus.mem_wr_en) begin
                    if (exp_q.size() == 0) begin
                        chk("wr_unexpected", bus.mem_wr_en, 1'b0);
                    end else begin
                        last_wr = exp_q.pop_front();
                        chk("wr_addr", bus.mem_wr_addr, last_wr.a);
                        chk("wr_data", bus.mem_wr_data, last_wr.d);
                    end
                end else begin
                    chk("hold_addr", bus.mem_wr_addr, last_wr.a);
                    chk("hold_data", bus.mem_wr_data, last_wr.d);
                end
            end
        end
    end

    task automatic clear_in();
        bus.fl_done    = 1'b0;
        bus.sl_done    = 1'b0;
        bus.fl_wr_en   = 1'b0;
        bus.sl_wr_en   = 1'b0;
        bus.fl_wr_addr = '0;
        bus.sl_wr_addr = '0;
        bus.fl_wr_data = '0;
        bus.sl_wr_data = '0;
    endtask

    task automatic drive_wr(input bit fl_ph, input int p, input bit en,
                            input bit bad);
        bus.fl_wr_en   = 1'b0;
        bus.sl_wr_en   = 1'b0;
        bus.fl_wr_addr = addr_t'($urandom_range(0, 127));
        bus.sl_wr_addr = addr_t'($urandom_range(0, 127));
        bus.fl_wr_data = rand_data();
        bus.sl_wr_data = rand_data();
        if (en) begin
            if (fl_ph) begin
                bus.fl_wr_en = 1'b1;
                exp_q.push_back('{a: bus.fl_wr_addr, d: bus.fl_wr_data});
            end else begin
                bus.sl_wr_en = 1'b1;
                exp_q.push_back('{a: sl_exp_addr(bus.sl_wr_addr, p),
                                  d: bus.sl_wr_data});
            end
        end
        if (bad) begin
            if (fl_ph) bus.sl_wr_en = 1'b1;
            else bus.fl_wr_en = 1'b1;
        end
    endtask

    task automatic drive_sl_fixed(input addr_t a, input addr_t ea);
        bus.fl_wr_en   = 1'b0;
        bus.sl_wr_en   = 1'b1;
        bus.sl_wr_addr = a;
        bus.sl_wr_data = rand_data();
        exp_q.push_back('{a: ea, d: bus.sl_wr_data});
    endtask

    task automatic wait_fl_start();
        for (int n = 0; n < 8 && bus.fl_start !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic wait_sl_start();
        for (int n = 0; n < 8 && bus.sl_start !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 8 && bus.done !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic check_zero();
        chk("z_fl_start", bus.fl_start, 1'b0);
        chk("z_sl_start", bus.sl_start, 1'b0);
        chk("z_mem_wr_en", bus.mem_wr_en, 1'b0);
        chk("z_mem_wr_addr", bus.mem_wr_addr, '0);
        chk("z_mem_wr_data", bus.mem_wr_data, '0);
        chk("z_bank_sel", bus.bank_sel, 1'b0);
        chk("z_pass_idx", bus.pass_idx, '0);
        chk("z_busy", bus.busy, 1'b0);
        chk("z_done", bus.done, 1'b0);
        chk("z_err", bus.err, 1'b0);
    endtask

    task automatic run_frame(input int fl_lat, input int sl_lat,
                             input bit hold, input bit rw, input bit bad,
                             input bit dir);
        int f0, s0, d0;
        bit exp_bank;
        f0 = fl_starts;
        s0 = sl_starts;
        d0 = dones;
        exp_bank = ~bank_model;
        bus.start = 1'b1;
        wait_fl_start();
        chk("fl_start", bus.fl_start, 1'b1);
        chk("start_err_clr", bus.err, 1'b0);
        chk("busy_run", bus.busy, 1'b1);
        if (!hold) bus.start = 1'b0;
        for (int k = 0; k < fl_lat; k++) begin
            drive_wr(1'b1, 0, rw && ($urandom_range(0, 1) == 1), bad && k == 1);
            @(negedge clk);
        end
        drive_wr(1'b1, 0, rw, 1'b0);
        bus.fl_done = 1'b1;
        @(negedge clk);
        clear_in();
        for (int p = 0; p < NUM_PASSES; p++) begin
            wait_sl_start();
            chk("sl_start", bus.sl_start, 1'b1);
            chk("pass_idx", bus.pass_idx, p);
            chk("bank_sel", bus.bank_sel, exp_bank);
            for (int k = 0; k < sl_lat; k++) begin
                if (dir && p == 1 && k == 0) drive_sl_fixed(5, 37);
                else if (dir && p == 1 && k == 1) drive_sl_fixed(100, 4);
                else drive_wr(1'b0, p, rw && ($urandom_range(0, 1) == 1), 1'b0);
                @(negedge clk);
            end
            drive_wr(1'b0, p, rw, 1'b0);
            bus.sl_done = 1'b1;
            @(negedge clk);
            clear_in();
        end
        wait_done();
        chk("done", bus.done, 1'b1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_pulse", bus.done, 1'b0);
        chk("busy_idle", bus.busy, 1'b0);
        chk("pass_idx_clr", bus.pass_idx, '0);
        chk("bank_sel_end", bus.bank_sel, exp_bank);
        chk("err_end", bus.err, bad);
        chk("fl_start_cnt", fl_starts - f0, 1);
        chk("sl_start_cnt", sl_starts - s0, NUM_PASSES);
        chk("done_cnt", dones - d0, 1);
        bank_model = exp_bank;
    endtask

    task automatic run_timeout();
        int n;
        bus.start = 1'b1;
        wait_fl_start();
        chk("tmo_fl_start", bus.fl_start, 1'b1);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TIMEOUT + 1);
        chk("tmo_err", bus.err, 1'b1);
        chk("tmo_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", bus.err, 1'b1);
    endtask

    task automatic run_reset_mid();
        bus.start = 1'b1;
        wait_fl_start();
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.fl_done = 1'b1;
        @(negedge clk);
        bus.fl_done = 1'b0;
        wait_sl_start();
        chk("rm_sl_start", bus.sl_start, 1'b1);
        @(negedge clk);
        chk("rm_busy", bus.busy, 1'b1);
        #2 rst = 1'b0;
        #1 check_zero();
        @(negedge clk);
        rst = 1'b1;
        bank_model = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        clear_in();
        repeat (3) @(negedge clk);
        check_zero();
        rst = 1'b1;
        @(negedge clk);

        bus.fl_done = 1'b1;
        bus.sl_done = 1'b1;
        @(negedge clk);
        clear_in();
        @(negedge clk);
        chk("stray_done_busy", bus.busy, 1'b0);
        chk("stray_done_done", bus.done, 1'b0);
        chk("stray_done_err", bus.err, 1'b0);

        run_frame(10, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4, 4, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(8, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(6, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(2, 20), $urandom_range(2, 12),
                      1'b0, 1'b1, 1'b0, 1'b0);
        end
        run_timeout();
        run_frame(5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(TIMEOUT, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_reset_mid();
        run_frame(7, 4, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("wr_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
